// File: rtl/bp_be_stride_pf_sched_if.sv
// Training-event bus and prefetch request handshake for the stride prefetch scheduler.
interface bp_be_stride_pf_sched_if #(
  parameter int unsigned vaddr_width_p  = 39,
  parameter int unsigned stride_width_p = 8
);

  logic                      train_v_i;
  logic [vaddr_width_p-1:0]  train_pc_i;
  logic [vaddr_width_p-1:0]  train_addr_i;
  logic [stride_width_p-1:0] train_stride_i;
  logic                      start_discovery_i;
  logic                      confirm_discovery_i;

  logic                      pf_v_o;
  logic [vaddr_width_p-1:0]  pf_addr_o;
  logic                      pf_ready_i;

  // Scheduler side: consumes training, produces prefetch requests.
  modport slave (
    input  train_v_i, train_pc_i, train_addr_i, train_stride_i,
    input  start_discovery_i, confirm_discovery_i, pf_ready_i,
    output pf_v_o, pf_addr_o
  );

  // Environment side: produces training, consumes prefetch requests.
  modport master (
    output train_v_i, train_pc_i, train_addr_i, train_stride_i,
    output start_discovery_i, confirm_discovery_i, pf_ready_i,
    input  pf_v_o, pf_addr_o
  );

endinterface

// File: rtl/bp_be_stride_pf_sched.sv
// Stride prefetch scheduler: turns stride training events into a small set of
// credit-limited streams and round-robins them onto one ready/valid port.
module bp_be_stride_pf_sched #(
  parameter int unsigned vaddr_width_p       = 39,
  parameter int unsigned stride_width_p      = 8,
  parameter int unsigned streams_p           = 4,
  parameter int unsigned degree_p            = 4,
  parameter int unsigned page_offset_width_p = 12
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  en_i,
  input  logic                  yield_i,
  output logic                  busy_o,
  bp_be_stride_pf_sched_if.slave pf_if
);

  localparam int unsigned credit_w_lp = $clog2(degree_p + 1);
  localparam int unsigned idx_w_lp    = (streams_p > 1) ? $clog2(streams_p) : 1;
  localparam int unsigned page_w_lp   = vaddr_width_p - page_offset_width_p;

  typedef logic [vaddr_width_p-1:0] vaddr_t;
  typedef logic [idx_w_lp-1:0]      idx_t;

  typedef struct packed {
    logic                      v;
    vaddr_t                    tag;
    vaddr_t                    next_addr;
    logic [stride_width_p-1:0] stride;
    logic [credit_w_lp-1:0]    credits;
    logic                      conf;
  } entry_t;

  function automatic vaddr_t sext(input logic [stride_width_p-1:0] s);
    return {{(vaddr_width_p - stride_width_p){s[stride_width_p-1]}}, s};
  endfunction

  function automatic logic [page_w_lp-1:0] page_of(input vaddr_t a);
    return a[vaddr_width_p-1:page_offset_width_p];
  endfunction

  entry_t entry_q [streams_p];
  entry_t entry_d [streams_p];
  idx_t   rr_ptr_q, rr_ptr_d;
  idx_t   victim_ptr_q, victim_ptr_d;
  logic   pf_v_q, pf_v_d;
  vaddr_t pf_addr_q, pf_addr_d;

  logic   slot_free;
  logic   grant_found;
  idx_t   grant_idx;
  idx_t   cand;
  vaddr_t issue_next;

  logic   train_act;
  vaddr_t train_tgt;
  logic   train_cross;
  logic   hit_found;
  idx_t   hit_idx;
  logic   inv_found;
  idx_t   inv_idx;
  idx_t   alloc_idx;
  logic   conf_eff;

  // Next-state for issue slot, stream table and pointers; training overrides issue.
  always_comb begin
    for (int unsigned i = 0; i < streams_p; i++) entry_d[i] = entry_q[i];
    rr_ptr_d     = rr_ptr_q;
    victim_ptr_d = victim_ptr_q;
    pf_v_d       = pf_v_q;
    pf_addr_d    = pf_addr_q;
    slot_free    = ~pf_v_q | pf_if.pf_ready_i;
    grant_found  = 1'b0;
    grant_idx    = '0;
    cand         = '0;
    issue_next   = '0;
    train_act    = en_i & pf_if.train_v_i & (pf_if.train_stride_i != '0);
    train_tgt    = pf_if.train_addr_i + sext(pf_if.train_stride_i);
    train_cross  = page_of(train_tgt) != page_of(pf_if.train_addr_i);
    hit_found    = 1'b0;
    hit_idx      = '0;
    inv_found    = 1'b0;
    inv_idx      = '0;
    alloc_idx    = '0;
    conf_eff     = 1'b0;

    // Issue: round-robin search starting just after the last grant.
    if (slot_free) begin
      pf_v_d = 1'b0;
      if (en_i && !yield_i) begin
        for (int unsigned i = 1; i <= streams_p; i++) begin
          cand = idx_w_lp'((32'(rr_ptr_q) + i) % streams_p);
          if (!grant_found && entry_q[cand].v && (entry_q[cand].credits != '0)) begin
            grant_found = 1'b1;
            grant_idx   = cand;
          end
        end
        if (grant_found) begin
          pf_v_d     = 1'b1;
          pf_addr_d  = entry_q[grant_idx].next_addr;
          issue_next = entry_q[grant_idx].next_addr + sext(entry_q[grant_idx].stride);
          entry_d[grant_idx].next_addr = issue_next;
          entry_d[grant_idx].credits   = entry_q[grant_idx].credits - credit_w_lp'(1);
          rr_ptr_d = grant_idx;
          if (page_of(issue_next) != page_of(entry_q[grant_idx].next_addr)) begin
            entry_d[grant_idx].v       = 1'b0;
            entry_d[grant_idx].credits = '0;
          end
        end
      end
    end

    // Tag lookup and lowest free slot, both against the pre-cycle table.
    for (int unsigned i = 0; i < streams_p; i++) begin
      if (!hit_found && entry_q[i].v && (entry_q[i].tag == pf_if.train_pc_i)) begin
        hit_found = 1'b1;
        hit_idx   = idx_w_lp'(i);
      end
      if (!inv_found && !entry_q[i].v) begin
        inv_found = 1'b1;
        inv_idx   = idx_w_lp'(i);
      end
    end

    // Training: discovery restart, refill/invalidate on hit, allocate on miss.
    if (train_act) begin
      if (pf_if.start_discovery_i) begin
        for (int unsigned i = 0; i < streams_p; i++) entry_d[i].conf = 1'b0;
      end
      if (hit_found) begin
        if (train_cross) begin
          entry_d[hit_idx].v       = 1'b0;
          entry_d[hit_idx].credits = '0;
        end else begin
          conf_eff = entry_q[hit_idx].conf & ~pf_if.start_discovery_i;
          entry_d[hit_idx].v         = 1'b1;
          entry_d[hit_idx].tag       = entry_q[hit_idx].tag;
          entry_d[hit_idx].next_addr = train_tgt;
          entry_d[hit_idx].stride    = pf_if.train_stride_i;
          entry_d[hit_idx].conf      = conf_eff;
          entry_d[hit_idx].credits   = conf_eff ? credit_w_lp'(degree_p) : credit_w_lp'(1);
          if (pf_if.confirm_discovery_i) begin
            entry_d[hit_idx].conf    = 1'b1;
            entry_d[hit_idx].credits = credit_w_lp'(degree_p);
          end
        end
      end else if (!train_cross) begin
        if (inv_found) begin
          alloc_idx = inv_idx;
        end else begin
          alloc_idx    = victim_ptr_q;
          victim_ptr_d = (victim_ptr_q == idx_w_lp'(streams_p - 1)) ? '0
                                                                   : victim_ptr_q + idx_w_lp'(1);
        end
        entry_d[alloc_idx].v         = 1'b1;
        entry_d[alloc_idx].tag       = pf_if.train_pc_i;
        entry_d[alloc_idx].next_addr = train_tgt;
        entry_d[alloc_idx].stride    = pf_if.train_stride_i;
        entry_d[alloc_idx].conf      = pf_if.confirm_discovery_i;
        entry_d[alloc_idx].credits   = pf_if.confirm_discovery_i ? credit_w_lp'(degree_p)
                                                                 : credit_w_lp'(1);
      end
    end

    // Disabled scheduler freezes the table and pointers; the slot still drains.
    if (!en_i) begin
      for (int unsigned i = 0; i < streams_p; i++) entry_d[i] = entry_q[i];
      rr_ptr_d     = rr_ptr_q;
      victim_ptr_d = victim_ptr_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int unsigned i = 0; i < streams_p; i++) entry_q[i] <= '0;
      rr_ptr_q     <= idx_w_lp'(streams_p - 1);
      victim_ptr_q <= '0;
      pf_v_q       <= 1'b0;
      pf_addr_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < streams_p; i++) entry_q[i] <= entry_d[i];
      rr_ptr_q     <= rr_ptr_d;
      victim_ptr_q <= victim_ptr_d;
      pf_v_q       <= pf_v_d;
      pf_addr_q    <= pf_addr_d;
    end
  end

  // Busy while a request is outstanding or any live stream still holds credit.
  always_comb begin
    busy_o = pf_v_q;
    for (int unsigned i = 0; i < streams_p; i++) begin
      if (entry_q[i].v && (entry_q[i].credits != '0)) busy_o = 1'b1;
    end
  end

  assign pf_if.pf_v_o    = pf_v_q;
  assign pf_if.pf_addr_o = pf_addr_q;

endmodule

// File: tb/tb_bp_be_stride_pf_sched.sv
// Scoreboard bench for the stride prefetch scheduler: directed scenarios plus
// random traffic, checked against a stream-level reference model.
module tb_bp_be_stride_pf_sched;

  localparam int unsigned VW  = 39;
  localparam int unsigned SW  = 8;
  localparam int          NS  = 4;
  localparam int          DEG = 4;
  localparam int unsigned PO  = 12;
  localparam longint unsigned AMASK = (64'd1 << VW) - 64'd1;

  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  logic en_i = 1'b0;
  logic yield_i = 1'b0;
  logic busy_o;

  bp_be_stride_pf_sched_if #(.vaddr_width_p(VW), .stride_width_p(SW)) pf_if ();

  bp_be_stride_pf_sched #(
    .vaddr_width_p(VW), .stride_width_p(SW), .streams_p(NS),
    .degree_p(DEG), .page_offset_width_p(PO)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .en_i(en_i), .yield_i(yield_i),
    .busy_o(busy_o), .pf_if(pf_if)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: one record per stream, plus the issue slot.
  typedef struct {
    bit              v;
    longint unsigned tag;
    longint unsigned nxt;
    longint          stride;
    int              cred;
    bit              conf;
  } mstream_t;

  mstream_t        ms [NS];
  int              m_rr;
  int              m_vic;
  bit              m_pf_v;
  longint unsigned m_pf_addr;

  longint unsigned exp_q  [$];
  longint unsigned got_q  [$];
  longint unsigned want_q [$];

  function automatic longint unsigned add_s(longint unsigned a, longint s);
    return (a + $unsigned(s)) & AMASK;
  endfunction

  function automatic bit same_page(longint unsigned a, longint unsigned b);
    return (a >> PO) == (b >> PO);
  endfunction

  function automatic void model_reset();
    foreach (ms[i]) ms[i] = '{v: 0, tag: 0, nxt: 0, stride: 0, cred: 0, conf: 0};
    m_rr      = NS - 1;
    m_vic     = 0;
    m_pf_v    = 0;
    m_pf_addr = 0;
  endfunction

  function automatic bit m_busy();
    bit b;
    b = m_pf_v;
    foreach (ms[i]) if (ms[i].v && ms[i].cred > 0) b = 1;
    return b;
  endfunction

  // One clock of model behaviour given the inputs presented this cycle.
  function automatic void model_step(bit en, bit trv, longint unsigned pc, longint unsigned addr,
                                     logic [7:0] st, bit start, bit conf, bit yld, bit rdy);
    mstream_t        pre [NS];
    longint          s;
    longint unsigned tgt;
    int              hit;
    int              slot;
    int              j;
    pre = ms;
    if (!m_pf_v || rdy) begin
      m_pf_v = 0;
      if (en && !yld) begin
        for (int k = 1; k <= NS; k++) begin
          j = (m_rr + k) % NS;
          if (pre[j].v && pre[j].cred > 0) begin
            m_pf_v    = 1;
            m_pf_addr = pre[j].nxt;
            exp_q.push_back(pre[j].nxt);
            ms[j].nxt  = add_s(pre[j].nxt, pre[j].stride);
            ms[j].cred = pre[j].cred - 1;
            m_rr       = j;
            if (!same_page(ms[j].nxt, pre[j].nxt)) begin
              ms[j].v    = 0;
              ms[j].cred = 0;
            end
            break;
          end
        end
      end
    end
    s = $signed(st);
    if (en && trv && s != 0) begin
      tgt = add_s(addr, s);
      if (start) foreach (ms[i]) ms[i].conf = 0;
      hit = -1;
      for (int i = NS - 1; i >= 0; i--) if (pre[i].v && pre[i].tag == pc) hit = i;
      if (hit >= 0) begin
        if (!same_page(tgt, addr)) begin
          ms[hit].v    = 0;
          ms[hit].cred = 0;
        end else begin
          ms[hit].v      = 1;
          ms[hit].tag    = pc;
          ms[hit].nxt    = tgt;
          ms[hit].stride = s;
          ms[hit].cred   = ms[hit].conf ? DEG : 1;
          if (conf) begin
            ms[hit].conf = 1;
            ms[hit].cred = DEG;
          end
        end
      end else if (same_page(tgt, addr)) begin
        slot = -1;
        for (int i = NS - 1; i >= 0; i--) if (!pre[i].v) slot = i;
        if (slot < 0) begin
          slot  = m_vic;
          m_vic = (m_vic + 1) % NS;
        end
        ms[slot] = '{v: 1, tag: pc, nxt: tgt, stride: s, cred: (conf ? DEG : 1), conf: conf};
      end
    end
  endfunction

  // Monitor: per-cycle valid/busy checks, hold stability, scoreboard pop on handshake.
  bit              prev_stall = 0;
  longint unsigned prev_addr  = 0;
  always @(negedge clk_i) begin
    longint unsigned a;
    longint unsigned e;
    if (reset_n_i) begin
      a = 64'(pf_if.pf_addr_o);
      checks++;
      if (pf_if.pf_v_o !== m_pf_v) begin
        errors++;
        $display("FAIL pf_v t=%0t got=%b want=%b", $time, pf_if.pf_v_o, m_pf_v);
      end
      checks++;
      if (busy_o !== m_busy()) begin
        errors++;
        $display("FAIL busy t=%0t got=%b want=%b", $time, busy_o, m_busy());
      end
      if (prev_stall) begin
        checks++;
        if (a !== prev_addr) begin
          errors++;
          $display("FAIL hold_addr t=%0t got=%h want=%h", $time, a, prev_addr);
        end
      end
      if (pf_if.pf_v_o && pf_if.pf_ready_i) begin
        got_q.push_back(a);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_req t=%0t got=%h want=none", $time, a);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            errors++;
            $display("FAIL req_addr t=%0t got=%h want=%h", $time, a, e);
          end
        end
      end
      prev_stall = pf_if.pf_v_o && !pf_if.pf_ready_i;
      prev_addr  = a;
    end else begin
      prev_stall = 0;
    end
  end

  task automatic cyc(bit en, bit trv, longint unsigned pc, longint unsigned addr, logic [7:0] st,
                     bit start, bit conf, bit yld, bit rdy);
    en_i                      = en;
    pf_if.train_v_i           = trv;
    pf_if.train_pc_i          = VW'(pc);
    pf_if.train_addr_i        = VW'(addr);
    pf_if.train_stride_i      = st;
    pf_if.start_discovery_i   = start;
    pf_if.confirm_discovery_i = conf;
    yield_i                   = yld;
    pf_if.pf_ready_i          = rdy;
    @(negedge clk_i);
    #1;
    model_step(en, trv, pc & AMASK, addr & AMASK, st, start, conf, yld, rdy);
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(int n, bit rdy, bit yld);
    repeat (n) cyc(1, 0, 0, 0, 8'h00, 0, 0, yld, rdy);
  endtask

  task automatic reset_dut();
    reset_n_i = 1'b0;
    en_i = 0; yield_i = 0;
    pf_if.train_v_i = 0; pf_if.train_pc_i = '0; pf_if.train_addr_i = '0;
    pf_if.train_stride_i = '0; pf_if.start_discovery_i = 0;
    pf_if.confirm_discovery_i = 0; pf_if.pf_ready_i = 0;
    model_reset();
    exp_q.delete();
    got_q.delete();
    repeat (2) @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
  endtask

  task automatic check_list(string name);
    checks++;
    if (got_q.size() != want_q.size()) begin
      errors++;
      $display("FAIL %s_count got=%0d want=%0d", name, got_q.size(), want_q.size());
    end
    for (int i = 0; i < got_q.size() && i < want_q.size(); i++) begin
      checks++;
      if (got_q[i] !== want_q[i]) begin
        errors++;
        $display("FAIL %s[%0d] got=%h want=%h", name, i, got_q[i], want_q[i]);
      end
    end
    want_q.delete();
  endtask

  longint unsigned r_pc;
  longint unsigned r_addr;
  logic [7:0]      r_st;
  int              drain;

  initial begin
    reset_dut();
    checks++;
    if (pf_if.pf_v_o !== 1'b0 || busy_o !== 1'b0 || pf_if.pf_addr_o !== '0) begin
      errors++;
      $display("FAIL reset_state got v=%b busy=%b addr=%h want=0/0/0",
               pf_if.pf_v_o, busy_o, pf_if.pf_addr_o);
    end

    // Unconfirmed stream: one request.
    cyc(1, 1, 64'h80001000, 64'h2000, 8'h40, 0, 0, 0, 1);
    idle(6, 1, 0);
    want_q.push_back(64'h2040);
    check_list("unconfirmed");

    // Confirmed stream: degree requests back to back.
    reset_dut();
    cyc(1, 1, 64'h80001000, 64'h2000, 8'h40, 0, 1, 0, 1);
    idle(8, 1, 0);
    want_q.push_back(64'h2040); want_q.push_back(64'h2080);
    want_q.push_back(64'h20C0); want_q.push_back(64'h2100);
    check_list("confirmed");

    // Backpressure then yield.
    reset_dut();
    cyc(1, 1, 64'h80001000, 64'h2000, 8'h40, 0, 1, 0, 0);
    idle(4, 0, 0);
    idle(4, 1, 1);
    checks++;
    if (got_q.size() != 1) begin
      errors++;
      $display("FAIL yield_block got=%0d want=1", got_q.size());
    end
    idle(8, 1, 0);
    want_q.push_back(64'h2040); want_q.push_back(64'h2080);
    want_q.push_back(64'h20C0); want_q.push_back(64'h2100);
    check_list("backpressure");

    // Page limit, positive stride.
    reset_dut();
    cyc(1, 1, 64'h80001000, 64'h2F80, 8'h40, 0, 1, 0, 1);
    idle(8, 1, 0);
    want_q.push_back(64'h2FC0);
    check_list("page_up");

    // Page limit, negative stride.
    reset_dut();
    cyc(1, 1, 64'h80001000, 64'h2040, 8'hC0, 0, 1, 0, 1);
    idle(8, 1, 0);
    want_q.push_back(64'h2000);
    check_list("page_down");

    // Training target already across the page: nothing allocated.
    reset_dut();
    cyc(1, 1, 64'h80001000, 64'h2FF0, 8'h40, 0, 1, 0, 1);
    idle(6, 1, 0);
    check_list("page_cross_train");

    // Five confirmed streams: fifth replaces entry 0, grants rotate.
    reset_dut();
    for (int p = 1; p <= 5; p++)
      cyc(1, 1, 64'h1000 * longint'(p), 64'h10000 * longint'(p), 8'h40, 0, 1, 0, 1);
    idle(20, 1, 0);
    want_q.push_back(64'h10040);
    for (int k = 1; k <= 4; k++)
      for (int p = 2; p <= 5; p++)
        want_q.push_back(64'h10000 * longint'(p) + 64'h40 * longint'(k));
    check_list("replace_rr");

    // Reset in the second issue cycle of a confirmed burst.
    reset_dut();
    cyc(1, 1, 64'h80001000, 64'h2000, 8'h40, 0, 1, 0, 1);
    idle(2, 1, 0);
    #1;
    reset_n_i = 1'b0;
    #1;
    checks++;
    if (pf_if.pf_v_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got v=%b busy=%b want=0/0", pf_if.pf_v_o, busy_o);
    end
    model_reset();
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    idle(6, 1, 0);
    want_q.push_back(64'h2040);
    check_list("reset_burst");

    // Random traffic against the model.
    reset_dut();
    for (int n = 0; n < 2000; n++) begin
      r_pc   = 64'h400 * longint'($urandom_range(0, 5));
      r_addr = {$urandom, $urandom} & AMASK;
      case ($urandom_range(0, 3))
        0: r_addr = (r_addr & ~64'hFFF) | 64'hF80 | longint'($urandom_range(0, 127));
        1: r_addr = (r_addr & ~64'hFFF) | longint'($urandom_range(0, 127));
        default: ;
      endcase
      r_st = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0) r_st = 8'($signed(r_st) >>> 3);
      cyc($urandom_range(0, 15) != 0, $urandom_range(0, 2) == 0, r_pc, r_addr, r_st,
          $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0);
    end

    // Drain, bounded.
    drain = 0;
    while ((exp_q.size() != 0 || m_busy()) && drain < 200) begin
      idle(1, 1, 0);
      drain++;
    end
    idle(2, 1, 0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_pending got=%0d want=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
